// File: rtl/ncc_sequencer.sv
// Load/stream sequencer for the 16x16 log-domain NCC PE grid: fills the descriptor
// registers word by word, then streams window pixels and flags valid correlation columns.
module ncc_sequencer #(
   parameter int NUM_ROWS       = 16,
   parameter int NUM_COL_GROUPS = 4,
   parameter int PIPE_DEPTH     = 16,
   parameter int WIN_LEN        = 640
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              keep_desc,
   input  logic                              abort,
   input  logic                              desc_valid,
   output logic                              desc_ready,
   output logic                              desc_load_en,
   output logic [$clog2(NUM_ROWS)-1:0]       desc_row,
   output logic [$clog2(NUM_COL_GROUPS)-1:0] desc_col_grp,
   input  logic                              win_valid,
   output logic                              win_ready,
   output logic                              win_load_en,
   output logic                              acc_load_en,
   output logic                              result_valid,
   output logic [$clog2(WIN_LEN)-1:0]        result_col,
   output logic                              desc_loaded,
   output logic                              busy,
   output logic                              done
);

   localparam int ROW_W = $clog2(NUM_ROWS);
   localparam int GRP_W = $clog2(NUM_COL_GROUPS);
   localparam int COL_W = $clog2(WIN_LEN);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_COL_GROUPS - 1);
   localparam logic [COL_W-1:0] PIX_LAST = COL_W'(WIN_LEN - 1);
   localparam logic [COL_W-1:0] PIPE_M1  = COL_W'(PIPE_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DESC_LOAD  = 2'd1,
      WIN_STREAM = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [ROW_W-1:0]   row_r;
   logic [GRP_W-1:0]   grp_r;
   logic [COL_W-1:0]   pix_r;
   logic               desc_loaded_r;
   logic               result_valid_r;
   logic [COL_W-1:0]   result_col_r;
   logic               desc_hs_s;
   logic               win_hs_s;
   logic               last_word_s;
   logic               last_pix_s;
   logic               col_out_s;

   // abort drops ready in the same cycle so it always wins over a handshake
   assign desc_ready   = (state_r == DESC_LOAD) && !abort;
   assign win_ready    = (state_r == WIN_STREAM) && !abort;
   assign desc_hs_s    = desc_ready && desc_valid;
   assign win_hs_s     = win_ready && win_valid;
   assign desc_load_en = desc_hs_s;
   assign win_load_en  = win_hs_s;
   assign acc_load_en  = win_hs_s;

   assign last_word_s  = (row_r == ROW_LAST) && (grp_r == GRP_LAST);
   assign last_pix_s   = (pix_r == PIX_LAST);
   assign col_out_s    = win_hs_s && (pix_r >= PIPE_M1);

   assign desc_row     = row_r;
   assign desc_col_grp = grp_r;
   assign desc_loaded  = desc_loaded_r;
   assign result_valid = result_valid_r;
   assign result_col   = result_col_r;
   assign busy         = (state_r != IDLE);
   assign done         = (state_r == DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start && !abort) begin
               if (keep_desc && desc_loaded_r) begin
                  state_nxt_s = WIN_STREAM;
               end else begin
                  state_nxt_s = DESC_LOAD;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DESC_LOAD: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (desc_hs_s && last_word_s) begin
               state_nxt_s = WIN_STREAM;
            end else begin
               state_nxt_s = DESC_LOAD;
            end
         end
         WIN_STREAM: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (win_hs_s && last_pix_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WIN_STREAM;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Descriptor row/group and window pixel counters, advanced only on handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_r <= '0;
         grp_r <= '0;
         pix_r <= '0;
      end else if (abort) begin
         row_r <= '0;
         grp_r <= '0;
         pix_r <= '0;
      end else begin
         if (desc_hs_s) begin
            if (grp_r == GRP_LAST) begin
               grp_r <= '0;
               row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
            end else begin
               grp_r <= grp_r + GRP_W'(1);
            end
         end
         if (win_hs_s) begin
            pix_r <= last_pix_s ? '0 : pix_r + COL_W'(1);
         end
      end
   end

   // Descriptor residency: cleared when a reload begins, set by the final word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         desc_loaded_r <= 1'b0;
      end else if ((state_r == IDLE) && (state_nxt_s == DESC_LOAD)) begin
         desc_loaded_r <= 1'b0;
      end else if (desc_hs_s && last_word_s) begin
         desc_loaded_r <= 1'b1;
      end
   end

   // Result flag: a column leaves the grid once PIPE_DEPTH pixels have been accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_valid_r <= 1'b0;
         result_col_r   <= '0;
      end else begin
         result_valid_r <= col_out_s;
         if (col_out_s) begin
            result_col_r <= pix_r - PIPE_M1;
         end
      end
   end

endmodule

// File: tb/tb_ncc_sequencer.sv
// Randomised bench for ncc_sequencer against a pass-level reference model
// (word/pixel counts, row = word/4, result column = pixel - 15).
module tb_ncc_sequencer;

   localparam int NW = 64;
   localparam int WL = 640;
   localparam int PD = 16;
   localparam int M_IDLE = 0;
   localparam int M_DESC = 1;
   localparam int M_WIN  = 2;
   localparam int M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       keep_desc = 1'b0;
   logic       abort = 1'b0;
   logic       desc_valid = 1'b0;
   logic       desc_ready;
   logic       desc_load_en;
   logic [3:0] desc_row;
   logic [1:0] desc_col_grp;
   logic       win_valid = 1'b0;
   logic       win_ready;
   logic       win_load_en;
   logic       acc_load_en;
   logic       result_valid;
   logic [9:0] result_col;
   logic       desc_loaded;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: pass phase, words/pixels accepted, residency, last result
   int m_mode = M_IDLE;
   int m_w    = 0;
   int m_p    = 0;
   int m_loaded = 0;
   int m_rv   = 0;
   int m_rcol = 0;

   int desc_cnt, res_cnt, done_cnt;

   ncc_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .keep_desc(keep_desc), .abort(abort),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_load_en(desc_load_en),
      .desc_row(desc_row), .desc_col_grp(desc_col_grp),
      .win_valid(win_valid), .win_ready(win_ready), .win_load_en(win_load_en),
      .acc_load_en(acc_load_en), .result_valid(result_valid), .result_col(result_col),
      .desc_loaded(desc_loaded), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_outs_zero(input string tag);
      logic [25:0] outs;
      outs = {desc_ready, desc_load_en, desc_row, desc_col_grp, win_ready, win_load_en,
              acc_load_en, result_valid, result_col, desc_loaded, busy, done};
      check(tag, int'(outs), 0);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_w = 0; m_p = 0; m_loaded = 0; m_rv = 0; m_rcol = 0;
   endtask

   // one clock: drive at negedge, compare against the model, then advance the model
   task automatic cycle(input bit st, input bit kd, input bit ab, input bit dv, input bit wv);
      int e_dr, e_wr, hs_d, hs_w;
      @(negedge clk);
      start = st; keep_desc = kd; abort = ab; desc_valid = dv; win_valid = wv;
      #1;
      e_dr = (m_mode == M_DESC && !ab) ? 1 : 0;
      e_wr = (m_mode == M_WIN && !ab) ? 1 : 0;
      hs_d = e_dr & int'(dv);
      hs_w = e_wr & int'(wv);
      check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
      check("done", int'(done), (m_mode == M_DONE) ? 1 : 0);
      check("desc_ready", int'(desc_ready), e_dr);
      check("desc_load_en", int'(desc_load_en), hs_d);
      check("win_ready", int'(win_ready), e_wr);
      check("win_load_en", int'(win_load_en), hs_w);
      check("acc_load_en", int'(acc_load_en), hs_w);
      check("desc_loaded", int'(desc_loaded), m_loaded);
      check("result_valid", int'(result_valid), m_rv);
      check("result_col", int'(result_col), m_rcol);
      if (m_mode == M_DESC) begin
         check("desc_row", int'(desc_row), m_w / 4);
         check("desc_col_grp", int'(desc_col_grp), m_w % 4);
      end
      desc_cnt += int'(desc_load_en);
      res_cnt  += int'(result_valid);
      done_cnt += int'(done);

      m_rv = (hs_w == 1 && m_p >= PD - 1) ? 1 : 0;
      if (m_rv == 1) m_rcol = m_p - (PD - 1);
      case (m_mode)
         M_IDLE: begin
            if (st && !ab) begin
               if (kd && m_loaded == 1) begin
                  m_mode = M_WIN; m_p = 0;
               end else begin
                  m_mode = M_DESC; m_w = 0; m_loaded = 0;
               end
            end
         end
         M_DESC: begin
            if (ab) m_mode = M_IDLE;
            else if (hs_d == 1) begin
               m_w++;
               if (m_w == NW) begin
                  m_loaded = 1; m_mode = M_WIN; m_p = 0;
               end
            end
         end
         M_WIN: begin
            if (ab) m_mode = M_IDLE;
            else if (hs_w == 1) begin
               m_p++;
               if (m_p == WL) m_mode = M_DONE;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      start = 1'b1;
      #3 rst = 1'b1;
      #1;
      check_outs_zero({tag, "_async"});
      model_reset();
      repeat (3) begin
         @(negedge clk);
         #1;
         check({tag, "_busy_in_rst"}, int'(busy), 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
   endtask

   // vmode 0: valids always high, 1: toggle 1,0,1,0, 2: random
   task automatic run_pass(input string name, input bit kd, input int vmode, input int abort_pix,
                           input int rst_word, input int exp_desc, input int exp_res, input int exp_done);
      bit st, dv, wv, ab;
      desc_cnt = 0; res_cnt = 0; done_cnt = 0;
      cycle(1'b1, kd, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20000 && m_mode != M_IDLE; i++) begin
         case (vmode)
            0:       begin dv = 1'b1; wv = 1'b1; end
            1:       begin dv = (i % 2 == 0); wv = (i % 2 == 0); end
            default: begin dv = ($urandom_range(0, 3) != 0); wv = ($urandom_range(0, 3) != 0); end
         endcase
         st = 1'($urandom_range(0, 1));
         ab = 1'b0;
         if (m_mode == M_WIN && m_p == abort_pix) begin
            ab = 1'b1; wv = 1'b1;
         end
         if (m_mode == M_DESC && m_w == rst_word) begin
            async_reset(name);
            break;
         end
         cycle(st, 1'($urandom_range(0, 1)), ab, dv, wv);
      end
      check({name, "_timeout"}, m_mode, M_IDLE);
      check({name, "_desc_strobes"}, desc_cnt, exp_desc);
      check({name, "_results"}, res_cnt, exp_res);
      check({name, "_done_pulses"}, done_cnt, exp_done);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_outs_zero("reset_outs");
      rst = 1'b0;
      model_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      run_pass("full",        1'b0, 0,  -1, -1, NW, WL - PD + 1, 1);
      run_pass("keep",        1'b1, 0,  -1, -1, 0,  WL - PD + 1, 1);
      run_pass("toggle",      1'b0, 1,  -1, -1, NW, WL - PD + 1, 1);
      run_pass("abort",       1'b1, 0, 300, -1, 0,  300 - PD + 1, 0);
      run_pass("after_abort", 1'b1, 2,  -1, -1, 0,  WL - PD + 1, 1);

      // start together with abort in IDLE is ignored
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      async_reset("idle_rst");
      run_pass("keep_noload", 1'b1, 0,  -1, -1, NW, WL - PD + 1, 1);
      run_pass("rst_mid",     1'b0, 2,  -1, 28, 28, 0, 0);
      run_pass("rand",        1'b0, 2,  -1, -1, NW, WL - PD + 1, 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ncc_sequencer.md
Name: ncc_sequencer

Overview:
- Control sequencer for the 16x16 log-domain NCC processing-element grid.
- Accepts a descriptor word stream of 4 packed 8-bit pixels per word and generates row/column-group load strobes until all 256 descriptor pixels are in the grid.
- Then streams window pixels into the grid with per-pixel window/accumulator load strobes and flags each valid correlation column as it leaves the grid.
- Sits between the descriptor/window memory fetch logic and the PE grid; it owns all grid load enables.

Parameters:
- NUM_ROWS, 16, PE grid rows; one descriptor row per grid row.
- NUM_COL_GROUPS, 4, 32-bit descriptor words per grid row (4 pixels per word).
- PIPE_DEPTH, 16, PEs per row; a window pixel contributes to an output after this many accepted pixels.
- WIN_LEN, 640, window pixels streamed per pass; must be >= PIPE_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a pass; honoured only in IDLE.
- keep_desc  in  1  sampled with start; 1 = reuse the already-loaded descriptor and skip DESC_LOAD.
- abort  in  1  synchronous cancel; forces IDLE.
- desc_valid  in  1  descriptor word available upstream.
- desc_ready  out  1  sequencer accepts a descriptor word.
- desc_load_en  out  1  grid descriptor-register load strobe.
- desc_row  out  $clog2(NUM_ROWS)  grid row targeted by the current word.
- desc_col_grp  out  $clog2(NUM_COL_GROUPS)  column group targeted by the current word.
- win_valid  in  1  window pixel available upstream.
- win_ready  out  1  sequencer accepts a window pixel.
- win_load_en  out  1  grid window-register load strobe.
- acc_load_en  out  1  grid accumulator-register load strobe.
- result_valid  out  1  grid accumulator outputs hold a valid correlation column.
- result_col  out  $clog2(WIN_LEN)  window column index of the current result.
- desc_loaded  out  1  a complete descriptor is resident in the grid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:

Reset values:
- Reset forces IDLE and clears all counters.
- All outputs reset to 0, including desc_loaded.

States:
- IDLE → DESC_LOAD on start when keep_desc = 0, or when desc_loaded = 0 (a keep_desc request without a loaded descriptor falls back to a full load).
- IDLE → WIN_STREAM on start when keep_desc = 1 and desc_loaded = 1.
- DESC_LOAD: desc_ready = 1.
  - desc_load_en = desc_valid & desc_ready (combinational, same cycle as the handshake).
  - desc_row and desc_col_grp present the target of the word currently on the bus.
  - On each handshake, desc_col_grp increments. On wrap from NUM_COL_GROUPS-1 to 0, desc_row increments.
  - The handshake on word NUM_ROWS*NUM_COL_GROUPS-1 (row 15, group 3) sets desc_loaded and moves to WIN_STREAM next cycle. Row and group counters return to 0.
  - desc_loaded is cleared on entry to DESC_LOAD.
- WIN_STREAM: win_ready = 1.
  - win_load_en = acc_load_en = win_valid & win_ready (same cycle).
  - Pixel counter n (0-based) increments per handshake.
  - Handshake on pixel WIN_LEN-1 → DONE next cycle; n clears.
- DONE: done = 1 for exactly one cycle → IDLE. busy is still 1 in DONE.

Results:
- result_valid is registered: it asserts the cycle after the handshake of pixel n when n >= PIPE_DEPTH-1, with result_col = n-(PIPE_DEPTH-1).
- Otherwise result_valid = 0 and result_col holds its last value.
- A pass yields exactly WIN_LEN-PIPE_DEPTH+1 results (625 at defaults), result_col 0..624.

Stalls:
- Upstream valid low inserts bubbles.
- Every strobe is gated by its handshake.
- No counter advances and no result is issued during a stall.

Abort:
- abort in any non-IDLE state → IDLE next cycle; counters cleared; no done pulse.
- desc_loaded is cleared if aborted during DESC_LOAD and preserved if aborted during WIN_STREAM or DONE.
- abort has priority over a handshake in the same cycle: the strobe is suppressed (ready is forced 0 that cycle).

Other boundary rules:
- start while busy is ignored. start and abort together in IDLE: stay IDLE.
- Asynchronous rst mid-pass behaves as a reset.
- desc_ready and win_ready are never high together.

Test Plan:
- Reset then start with keep_desc = 0; 64 back-to-back desc words.
  - desc_load_en is high for 64 cycles; (row, grp) runs (0,0),(0,1),…,(15,3).
  - desc_loaded rises after word 63.
  - Then 640 back-to-back pixels: 625 result_valid pulses, result_col 0..624, the first one cycle after pixel 15.
  - done pulses once.
- desc_valid toggled 1,0,1,0 during load.
  - desc_row/desc_col_grp advance only on handshakes; still exactly 64 desc_load_en strobes.
- Second start with keep_desc = 1 after a completed pass.
  - Goes straight to WIN_STREAM; desc_ready never asserts; desc_loaded stays 1.
- start with keep_desc = 1 directly after reset (desc_loaded = 0).
  - Full DESC_LOAD occurs.
- abort asserted during WIN_STREAM at pixel 300, in the same cycle as win_valid.
  - No win_load_en that cycle; IDLE next cycle; no done; desc_loaded stays 1.
  - The next pass restarts at result_col 0.
- rst asserted mid-DESC_LOAD (row 7).
  - All outputs return to 0 asynchronously.
  - start held high during busy has no effect.
